// File: rtl/pipe_stage_skid_latch.sv
// pipe_stage_skid_latch: inter-stage pipeline latch with a two-entry skid buffer.
// in_ready depends only on state and rst, so back-pressure is never combinational.
// Ports:
//   clk, rst (sync, active-high), flush
//   in_valid / in_ready / in_data     upstream handshake and payload
//   out_valid / out_ready / out_data  downstream handshake and payload
//   stall_cnt, flush_cnt              perf counters (PIPE_LATCH_PERF_EN only)
// Build option: define PIPE_LATCH_PERF_EN to add saturating stall/flush counters.
module pipe_stage_skid_latch #(
    parameter int unsigned       DATA_W     = 32,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter int unsigned       CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_LATCH_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_fire;
    logic              out_fire;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    assign in_ready  = (state_q != SKID) && !rst;
    assign out_valid = (state_q != EMPTY);
    // Hide stale main contents whenever nothing live is held.
    assign out_data  = out_valid ? main_q : BUBBLE_VAL;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Squash everything; a same-cycle in_fire is dropped.
            state_d = EMPTY;
            main_d  = BUBBLE_VAL;
            skid_d  = BUBBLE_VAL;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = FULL;
                        main_d  = in_data;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = SKID;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    if (out_fire) begin
                        state_d = FULL;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE_VAL;
            skid_q  <= BUBBLE_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_LATCH_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters; flush does not clear them.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid_latch.sv
// tb_pipe_stage_skid_latch: scoreboard bench for pipe_stage_skid_latch.
// Accepted words queue up; delivered words must match the queue head.
module tb_pipe_stage_skid_latch;

    localparam int unsigned CNT_W = 4;
    localparam int          MAXC  = (1 << CNT_W) - 1;
    localparam logic [31:0] BUB   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
`ifdef PIPE_LATCH_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
`endif

    logic [31:0] sb[$];
    int m_stall = 0;
    int m_flush = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_stage_skid_latch #(
        .DATA_W    (32),
        .BUBBLE_VAL(BUB),
        .CNT_W     (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
`ifdef PIPE_LATCH_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    // One clock: drive inputs, advance scoreboard at the edge, sample #1 later.
    task automatic step(input bit r, input bit f, input bit iv,
                        input logic [31:0] d, input bit ordy);
        bit inf, outf, stl;
        rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        inf  = iv && !r && (sb.size() < 2);
        outf = (sb.size() > 0) && ordy;
        stl  = (sb.size() > 0) && !ordy;
        @(posedge clk);
        if (r) begin
            sb.delete();
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (stl && m_stall < MAXC) m_stall++;
            if (f && m_flush < MAXC) m_flush++;
            if (f) begin
                sb.delete();
            end else begin
                if (outf) void'(sb.pop_front());
                if (inf) sb.push_back(d);
            end
        end
        #1;
    endtask

    function automatic logic [31:0] exp_data();
        return (sb.size() > 0) ? sb[0] : BUB;
    endfunction

    task automatic test_reset();
        step(1, 0, 1, 32'h1234, 1);
        step(1, 0, 1, 32'h1234, 1);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_valid got %0b want 0", out_valid);
        end
        n_cmp++;
        if (out_data !== BUB) begin
            n_bad++; $display("FAIL reset_data got %h want %h", out_data, BUB);
        end
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_ready got %0b want 0", in_ready);
        end
        step(0, 0, 0, 0, 1);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL release_ready got %0b want 1", in_ready);
        end
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 16; i++) begin
            step(0, 0, 1, 32'(i), 1);
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
                n_bad++;
                $display("FAIL stream[%0d] got v=%0b d=%h want v=1 d=%h",
                         i, out_valid, out_data, 32'(i));
            end
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_bad++; $display("FAIL stream_ready[%0d] got %0b want 1", i, in_ready);
            end
        end
        step(0, 0, 0, 0, 1);
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== BUB) begin
            n_bad++;
            $display("FAIL stream_drain got v=%0b d=%h want v=0 d=%h",
                     out_valid, out_data, BUB);
        end
    endtask

    task automatic test_skid();
        step(0, 0, 1, 32'hA, 0);
        step(0, 0, 1, 32'hB, 0);
        n_cmp++;
        if (in_ready !== 1'b0 || out_data !== 32'hA) begin
            n_bad++;
            $display("FAIL skid_full got rdy=%0b d=%h want rdy=0 d=a", in_ready, out_data);
        end
        step(0, 0, 1, 32'hEE, 0);
        n_cmp++;
        if (out_data !== 32'hA || sb.size() != 2) begin
            n_bad++; $display("FAIL skid_hold got d=%h want a", out_data);
        end
        step(0, 0, 0, 0, 1);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'hB || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL skid_drain got v=%0b d=%h rdy=%0b want v=1 d=b rdy=1",
                     out_valid, out_data, in_ready);
        end
        step(0, 0, 0, 0, 1);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL skid_empty got v=%0b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        step(0, 0, 1, 32'hA, 0);
        step(0, 0, 1, 32'hB, 0);
        step(0, 1, 1, 32'hC, 0);
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== BUB) begin
            n_bad++;
            $display("FAIL flush_bubble got v=%0b d=%h want v=0 d=%h",
                     out_valid, out_data, BUB);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 1);
            n_cmp++;
            if (out_valid !== 1'b0 || out_data !== BUB) begin
                n_bad++;
                $display("FAIL flush_leak[%0d] got v=%0b d=%h want v=0 d=%h",
                         i, out_valid, out_data, BUB);
            end
        end
    endtask

    task automatic test_flush_rst();
        step(0, 0, 1, 32'h55, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 32'h66, 0);
        step(1, 1, 1, 32'h77, 1);
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== BUB || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rstflush got v=%0b d=%h rdy=%0b want v=0 d=%h rdy=0",
                     out_valid, out_data, in_ready, BUB);
        end
`ifdef PIPE_LATCH_PERF_EN
        n_cmp++;
        if (stall_cnt !== '0 || flush_cnt !== '0) begin
            n_bad++;
            $display("FAIL rstflush_cnt got st=%0d fl=%0d want 0 0", stall_cnt, flush_cnt);
        end
`endif
        step(0, 0, 0, 0, 1);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rstflush_after got v=%0b rdy=%0b want v=0 rdy=1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            step(0, ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                 $urandom, ($urandom_range(0, 2) != 0));
            n_cmp++;
            if (out_valid !== (sb.size() > 0) || out_data !== exp_data()
                || in_ready !== (sb.size() < 2)) begin
                n_bad++;
                $display("FAIL b2b[%0d] got v=%0b d=%h rdy=%0b want v=%0b d=%h rdy=%0b",
                         i, out_valid, out_data, in_ready,
                         (sb.size() > 0), exp_data(), (sb.size() < 2));
            end
`ifdef PIPE_LATCH_PERF_EN
            n_cmp++;
            if (stall_cnt !== CNT_W'(m_stall) || flush_cnt !== CNT_W'(m_flush)) begin
                n_bad++;
                $display("FAIL b2b_cnt[%0d] got st=%0d fl=%0d want st=%0d fl=%0d",
                         i, stall_cnt, flush_cnt, m_stall, m_flush);
            end
`endif
        end
        step(0, 1, 0, 0, 1);
    endtask

`ifdef PIPE_LATCH_PERF_EN
    task automatic test_perf();
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 32'h99, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0);
        n_cmp++;
        if (stall_cnt !== CNT_W'(15)) begin
            n_bad++; $display("FAIL perf_stall got %0d want 15", stall_cnt);
        end
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        n_cmp++;
        if (flush_cnt !== CNT_W'(3) || stall_cnt !== CNT_W'(15)) begin
            n_bad++;
            $display("FAIL perf_flush got fl=%0d st=%0d want fl=3 st=15",
                     flush_cnt, stall_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_flush_rst();
        test_back_to_back();
`ifdef PIPE_LATCH_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
